mem_resp_server: RTL and testbench

Synthesizable memory responder for the server side of `MemIntf`. It accepts read and write requests from an initiator such as the fetch unit, and services them against an internal word array. It returns responses in order, with the request's opaque field echoed, after a configurable fixed latency. Responses are buffered so the initiator may apply backpressure. The block replaces the FL test memory in RTL-level integration and gives benches a cycle-accurate memory.

---
 rtl/mem_server_pkg.sv | 39 +++
 rtl/mem_resp_fifo.sv | 51 +++++
 rtl/mem_resp_server.sv | 177 +++++++++++++++++
 tb/tb_mem_resp_server.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_server_pkg.sv
// Shared constants, message structs and byte-lane helpers for the memory response server.
package mem_server_pkg;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  localparam int MEM_OPAQ_BITS = 8;

  typedef struct packed {
    logic                     op;
    logic [MEM_OPAQ_BITS-1:0] opaque;
    logic [31:0]              addr;
    logic [1:0]               len;
    logic [31:0]              data;
  } mem_req_t;

  typedef struct packed {
    logic                     op;
    logic [MEM_OPAQ_BITS-1:0] opaque;
    logic [31:0]              addr;
    logic [1:0]               len;
    logic [31:0]              data;
  } mem_resp_t;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

  // Lanes from the byte offset up to the word boundary; overflow lanes are simply dropped.
  function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [2:0] nBytes);
    logic [3:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      mask[k] = (k >= int'(off)) && (k < int'(off) + int'(nBytes));
    end
    return mask;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// In-order response buffer with val/rdy on both sides; output is read straight from storage registers.
module mem_resp_fifo #(
  parameter int p_width = 8,
  parameter int p_depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [p_width-1:0]         in_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [p_width-1:0]         out_msg,
  output logic [$clog2(p_depth):0]   count
);

  localparam int c_cntW = $clog2(p_depth) + 1;
  localparam int c_ptrW = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [p_width-1:0] r_buf [p_depth];
  logic [c_ptrW-1:0]  r_wrPtr;
  logic [c_ptrW-1:0]  r_rdPtr;
  logic [c_cntW-1:0]  r_count;
  logic               w_push;
  logic               w_pop;

  assign in_rdy  = (r_count < c_cntW'(p_depth));
  assign out_val = (r_count != '0);
  assign out_msg = r_buf[r_rdPtr];
  assign count   = r_count;
  assign w_push  = in_val & in_rdy;
  assign w_pop   = out_val & out_rdy;

  // Pointers wrap at the depth, which need not be a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= (r_wrPtr == c_ptrW'(p_depth - 1)) ? '0 : r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= (r_rdPtr == c_ptrW'(p_depth - 1)) ? '0 : r_rdPtr + 1'b1;
      r_count <= r_count + c_cntW'(w_push) - c_cntW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wrPtr] <= in_msg;
  end

endmodule

// File: rtl/mem_resp_server.sv
// Cycle-accurate memory responder: word array accessed at accept, fixed-latency pipeline, then an
// in-order response buffer so the initiator can stall responses without losing any.
module mem_resp_server import mem_server_pkg::*; #(
  parameter int p_opaq_bits  = 8,
  parameter int p_num_words  = 256,
  parameter int p_latency    = 1,
  parameter int p_resp_depth = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  mem_req_t    req_msg,
  output logic        resp_val,
  input  logic        resp_rdy,
  output mem_resp_t   resp_msg,
  input  logic        init_en,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data
);

  localparam int c_idxW   = $clog2(p_num_words);
  localparam int c_cntW   = $clog2(p_resp_depth) + 1;
  localparam int c_stages = p_latency - 1;
  localparam int c_msgW   = $bits(mem_resp_t);

  if (p_opaq_bits != MEM_OPAQ_BITS || p_latency < 1 || p_resp_depth < p_latency) begin : g_badParams
    $error("mem_resp_server: unsupported parameter combination");
  end

  logic [31:0]       r_mem [p_num_words];
  logic              r_live;
  logic              w_accept;
  logic              w_doWrite;
  logic              w_doInit;
  logic              w_initHit;
  logic [c_idxW-1:0] w_reqIdx;
  logic [c_idxW-1:0] w_initIdx;
  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic [31:0]       w_word;
  logic [31:0]       w_masked;
  logic [31:0]       w_readData;
  logic [31:0]       w_wrData;
  logic [31:0]       w_base;
  logic [31:0]       w_merged;
  mem_resp_t         w_newResp;
  logic              w_pipeVal;
  mem_resp_t         w_pipeMsg;
  logic [c_cntW-1:0] w_inflight;
  logic [c_cntW-1:0] w_fifoCount;
  logic              w_fifoInRdy;
  logic              w_fifoVal;
  logic [c_msgW-1:0] w_fifoMsg;
  logic [c_cntW:0]   w_occupancy;
  logic              w_unusedInit;

  assign w_accept    = req_val & req_rdy;
  assign w_doWrite   = w_accept && (req_msg.op == MEM_OP_WRITE);
  assign w_doInit    = rst && init_en;
  assign w_reqIdx    = req_msg.addr[c_idxW+1:2];
  assign w_initIdx   = init_addr[c_idxW+1:2];
  assign w_initHit   = w_doInit && (w_initIdx == w_reqIdx);
  assign w_off       = req_msg.addr[1:0];
  assign w_mask      = byte_mask(w_off, len_bytes(req_msg.len));
  assign w_word      = r_mem[w_reqIdx];
  assign w_wrData    = req_msg.data << {w_off, 3'b000};
  assign w_readData  = w_masked >> {w_off, 3'b000};
  assign w_unusedInit = ^{init_addr[31:c_idxW+2], init_addr[1:0]};

  // Merge the request's lanes over the current word; a same-word backdoor write only keeps the other lanes.
  always_comb begin
    w_masked = '0;
    w_base   = w_initHit ? init_data : w_word;
    w_merged = w_base;
    for (int k = 0; k < 4; k++) begin
      if (w_mask[k]) begin
        w_masked[8*k +: 8] = w_word[8*k +: 8];
        w_merged[8*k +: 8] = w_wrData[8*k +: 8];
      end
    end
  end

  // Contents survive reset; backdoor writes are only blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (w_doWrite) r_mem[w_reqIdx] <= w_merged;
    if (w_doInit && !(w_doWrite && w_initHit)) r_mem[w_initIdx] <= init_data;
  end

  always_comb begin
    w_newResp.op     = req_msg.op;
    w_newResp.opaque = req_msg.opaque;
    w_newResp.addr   = req_msg.addr;
    w_newResp.len    = req_msg.len;
    w_newResp.data   = (req_msg.op == MEM_OP_WRITE) ? 32'h0 : w_readData;
  end

  if (c_stages == 0) begin : g_noPipe
    assign w_pipeVal  = w_accept;
    assign w_pipeMsg  = w_newResp;
    assign w_inflight = '0;
  end else begin : g_pipe
    logic [c_stages-1:0]      w_stgVal;
    mem_resp_t [c_stages-1:0] w_stgMsg;

    for (genvar g = 0; g < c_stages; g++) begin : g_stage
      logic      r_val;
      mem_resp_t r_msg;
      logic      w_inVal;
      mem_resp_t w_inMsg;

      if (g == 0) begin : g_first
        assign w_inVal = w_accept;
        assign w_inMsg = w_newResp;
      end else begin : g_next
        assign w_inVal = w_stgVal[g-1];
        assign w_inMsg = w_stgMsg[g-1];
      end

      always_ff @(posedge clk) begin
        if (!rst) r_val <= 1'b0;
        else      r_val <= w_inVal;
        r_msg <= w_inMsg;
      end

      assign w_stgVal[g] = r_val;
      assign w_stgMsg[g] = r_msg;
    end

    always_comb begin
      w_inflight = '0;
      for (int i = 0; i < c_stages; i++) begin
        w_inflight = w_inflight + c_cntW'(w_stgVal[i]);
      end
    end

    assign w_pipeVal = w_stgVal[c_stages-1];
    assign w_pipeMsg = w_stgMsg[c_stages-1];
  end

  mem_resp_fifo #(
    .p_width (c_msgW),
    .p_depth (p_resp_depth)
  ) u_respFifo (
    .clk     (clk),
    .rst     (rst),
    .in_val  (w_pipeVal),
    .in_rdy  (w_fifoInRdy),
    .in_msg  (w_pipeMsg),
    .out_val (w_fifoVal),
    .out_rdy (resp_rdy),
    .out_msg (w_fifoMsg),
    .count   (w_fifoCount)
  );

  // Ready is held low one extra cycle after reset releases and counts reserved pipeline slots.
  always_ff @(posedge clk) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

  assign w_occupancy = {1'b0, w_fifoCount} + {1'b0, w_inflight};
  assign req_rdy     = rst & r_live & w_fifoInRdy & (w_occupancy < (c_cntW + 1)'(p_resp_depth));
  assign resp_val    = rst & w_fifoVal;
  assign resp_msg    = w_fifoMsg;

  function automatic string trace();
    string sReq;
    string sResp;
    sReq  = "  ";
    sResp = "  ";
    if (req_val && req_rdy)   sReq  = $sformatf("%02h", req_msg.opaque);
    if (resp_val && resp_rdy) sResp = $sformatf("%02h", resp_msg.opaque);
    return $sformatf("%s > %s (%0d)", sReq, sResp, w_occupancy);
  endfunction

endmodule

// File: tb/tb_mem_resp_server.sv
// Directed bench for mem_resp_server: latency, partial access, back-to-back, backpressure, wrap, reset.
module tb_mem_resp_server;
  import mem_server_pkg::*;

  localparam int cDepth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  mem_req_t    req_msg;
  logic        resp_val;
  logic        resp_rdy = 1'b0;
  mem_resp_t   resp_msg;
  logic        init_en = 1'b0;
  logic [31:0] init_addr = '0;
  logic [31:0] init_data = '0;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mem_resp_server #(
    .p_opaq_bits  (8),
    .p_num_words  (256),
    .p_latency    (1),
    .p_resp_depth (cDepth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg   (req_msg),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_msg  (resp_msg),
    .init_en   (init_en),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // Inputs change just after the falling edge; outputs are sampled there, well away from the rising edge.
  task automatic applyStimulus(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                               input logic [1:0] len, input logic [31:0] data);
    req_val        = 1'b1;
    req_msg.op     = op;
    req_msg.opaque = opq;
    req_msg.addr   = addr;
    req_msg.len    = len;
    req_msg.data   = data;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if (req_rdy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_req_rdy: got %b expected 0", req_rdy); end
    checkCount++;
    if (resp_val !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_resp_val: got %b expected 0", resp_val); end
    rst = 1'b1;
    #1;
    checkCount++;
    if (req_rdy !== 1'b0) begin errorCount++; $display("[TB] FAIL first_cycle_after_reset_rdy: got %b expected 0", req_rdy); end
    @(negedge clk);
    checkCount++;
    if (req_rdy !== 1'b1) begin errorCount++; $display("[TB] FAIL ready_after_reset: got %b expected 1", req_rdy); end
  endtask

  task automatic test_read_latency();
    init_en = 1'b1; init_addr = 32'h0; init_data = 32'hDEADBEEF;
    @(negedge clk);
    init_en = 1'b0;
    resp_rdy = 1'b1;
    applyStimulus(MEM_OP_READ, 8'h05, 32'h0, 2'd0, 32'h0);
    checkCount++;
    if (resp_val !== 1'b0) begin errorCount++; $display("[TB] FAIL latency_early: got resp_val %b expected 0", resp_val); end
    @(negedge clk);
    req_val = 1'b0;
    checkCount++;
    if (resp_val !== 1'b1 || resp_msg.opaque !== 8'h05 || resp_msg.data !== 32'hDEADBEEF || resp_msg.op !== MEM_OP_READ)
      begin errorCount++; $display("[TB] FAIL preload_read: got val %b opq %h data %h expected 1 05 deadbeef", resp_val, resp_msg.opaque, resp_msg.data); end
    @(negedge clk);
    checkCount++;
    if (resp_val !== 1'b0) begin errorCount++; $display("[TB] FAIL resp_popped: got %b expected 0", resp_val); end
  endtask

  task automatic test_partial();
    applyStimulus(MEM_OP_WRITE, 8'h01, 32'h8, 2'd0, 32'h11223344);
    @(negedge clk);
    checkCount++;
    if (resp_val !== 1'b1 || resp_msg.op !== MEM_OP_WRITE || resp_msg.data !== 32'h0 || resp_msg.opaque !== 8'h01)
      begin errorCount++; $display("[TB] FAIL write_resp: got val %b op %b data %h opq %h expected 1 1 0 01", resp_val, resp_msg.op, resp_msg.data, resp_msg.opaque); end
    applyStimulus(MEM_OP_READ, 8'h02, 32'h9, 2'd2, 32'h0);
    @(negedge clk);
    checkCount++;
    if (resp_msg.data !== 32'h00002233 || resp_msg.addr !== 32'h9 || resp_msg.len !== 2'd2)
      begin errorCount++; $display("[TB] FAIL read_len2: got data %h addr %h len %0d expected 00002233 9 2", resp_msg.data, resp_msg.addr, resp_msg.len); end
    applyStimulus(MEM_OP_READ, 8'h03, 32'hB, 2'd3, 32'h0);
    @(negedge clk);
    checkCount++;
    if (resp_msg.data !== 32'h00000011) begin errorCount++; $display("[TB] FAIL read_truncated: got %h expected 00000011", resp_msg.data); end
    applyStimulus(MEM_OP_WRITE, 8'h04, 32'hB, 2'd2, 32'h00005566);
    @(negedge clk);
    applyStimulus(MEM_OP_READ, 8'h05, 32'h8, 2'd0, 32'h0);
    @(negedge clk);
    req_val = 1'b0;
    checkCount++;
    if (resp_msg.data !== 32'h66223344 || resp_msg.opaque !== 8'h05)
      begin errorCount++; $display("[TB] FAIL write_truncated: got data %h opq %h expected 66223344 05", resp_msg.data, resp_msg.opaque); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    applyStimulus(MEM_OP_WRITE, 8'h06, 32'h10, 2'd0, 32'hCAFEF00D);
    @(negedge clk);
    checkCount++;
    if (resp_val !== 1'b1 || resp_msg.opaque !== 8'h06) begin errorCount++; $display("[TB] FAIL b2b_write_resp: got val %b opq %h expected 1 06", resp_val, resp_msg.opaque); end
    applyStimulus(MEM_OP_READ, 8'h07, 32'h10, 2'd0, 32'h0);
    @(negedge clk);
    req_val = 1'b0;
    checkCount++;
    if (resp_val !== 1'b1 || resp_msg.opaque !== 8'h07 || resp_msg.data !== 32'hCAFEF00D)
      begin errorCount++; $display("[TB] FAIL b2b_read_resp: got val %b opq %h data %h expected 1 07 cafef00d", resp_val, resp_msg.opaque, resp_msg.data); end
    @(negedge clk);
    checkCount++;
    if (resp_val !== 1'b0) begin errorCount++; $display("[TB] FAIL b2b_drained: got %b expected 0", resp_val); end
  endtask

  task automatic test_overlap();
    init_en = 1'b1; init_addr = 32'h30; init_data = 32'hFFFFFFFF;
    applyStimulus(MEM_OP_WRITE, 8'h08, 32'h31, 2'd1, 32'h0);
    @(negedge clk);
    init_en = 1'b0;
    applyStimulus(MEM_OP_READ, 8'h09, 32'h30, 2'd0, 32'h0);
    @(negedge clk);
    req_val = 1'b0;
    checkCount++;
    if (resp_msg.data !== 32'hFFFF00FF) begin errorCount++; $display("[TB] FAIL backdoor_overlap: got %h expected ffff00ff", resp_msg.data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int  accepts;
    bit  full;
    accepts = 0;
    full = 1'b0;
    resp_rdy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_rdy) begin
        applyStimulus(MEM_OP_READ, 8'(accepts), 32'h0, 2'd0, 32'h0);
        accepts++;
      end else begin
        req_val = 1'b0;
        full = 1'b1;
        break;
      end
    end
    req_val = 1'b0;
    checkCount++;
    if (!full || accepts != cDepth) begin errorCount++; $display("[TB] FAIL accepts_until_full: got %0d (full %b) expected %0d", accepts, full, cDepth); end
    repeat (2) begin
      @(negedge clk);
      checkCount++;
      if (resp_val !== 1'b1 || resp_msg.opaque !== 8'h00 || resp_msg.data !== 32'hDEADBEEF || req_rdy !== 1'b0)
        begin errorCount++; $display("[TB] FAIL stall_stable: got val %b opq %h data %h rdy %b expected 1 00 deadbeef 0", resp_val, resp_msg.opaque, resp_msg.data, req_rdy); end
    end
    for (int i = 0; i < cDepth; i++) begin
      @(negedge clk);
      checkCount++;
      if (resp_val !== 1'b1 || resp_msg.opaque !== 8'(i))
        begin errorCount++; $display("[TB] FAIL drain_order: got val %b opq %h expected 1 %h", resp_val, resp_msg.opaque, 8'(i)); end
      if (i == 0) begin
        checkCount++;
        if (req_rdy !== 1'b0) begin errorCount++; $display("[TB] FAIL full_pop_no_bypass: got %b expected 0", req_rdy); end
        resp_rdy = 1'b1;
      end
      if (i == 1) begin
        checkCount++;
        if (req_rdy !== 1'b1) begin errorCount++; $display("[TB] FAIL freed_slot_next_cycle: got %b expected 1", req_rdy); end
      end
    end
    @(negedge clk);
    checkCount++;
    if (resp_val !== 1'b0) begin errorCount++; $display("[TB] FAIL drain_empty: got %b expected 0", resp_val); end
  endtask

  task automatic test_wrap();
    applyStimulus(MEM_OP_READ, 8'h0A, 32'h400, 2'd0, 32'h0);
    @(negedge clk);
    req_val = 1'b0;
    checkCount++;
    if (resp_msg.data !== 32'hDEADBEEF || resp_msg.opaque !== 8'h0A || resp_msg.addr !== 32'h400)
      begin errorCount++; $display("[TB] FAIL addr_wrap: got data %h opq %h addr %h expected deadbeef 0a 400", resp_msg.data, resp_msg.opaque, resp_msg.addr); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    applyStimulus(MEM_OP_WRITE, 8'h0B, 32'h20, 2'd0, 32'h0BADC0DE);
    @(negedge clk);
    req_val = 1'b0;
    @(negedge clk);
    resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(MEM_OP_READ, 8'(8'h10 + i), 32'h20, 2'd0, 32'h0);
      @(negedge clk);
    end
    req_val = 1'b0;
    checkCount++;
    if (resp_val !== 1'b1) begin errorCount++; $display("[TB] FAIL pending_before_reset: got %b expected 1", resp_val); end
    rst = 1'b0;
    #1;
    checkCount++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_mid_outputs: got val %b rdy %b expected 0 0", resp_val, req_rdy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkCount++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_mid_release: got val %b rdy %b expected 0 0", resp_val, req_rdy); end
    resp_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkCount++;
      if (resp_val !== 1'b0) begin errorCount++; $display("[TB] FAIL stale_response: got %b expected 0", resp_val); end
    end
    applyStimulus(MEM_OP_READ, 8'h0C, 32'h20, 2'd0, 32'h0);
    @(negedge clk);
    req_val = 1'b0;
    checkCount++;
    if (resp_val !== 1'b1 || resp_msg.data !== 32'h0BADC0DE || resp_msg.opaque !== 8'h0C)
      begin errorCount++; $display("[TB] FAIL memory_retained: got val %b data %h opq %h expected 1 0badc0de 0c", resp_val, resp_msg.data, resp_msg.opaque); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_msg = '0;
    test_reset();
    test_read_latency();
    test_partial();
    test_back_to_back();
    test_overlap();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
